// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction
// fetch and load/store, data first, with a bounded fetch starvation guard.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_f_req,
   input  logic [31:0] i_f_addr,
   output logic        o_f_valid,
   output logic        o_f_err,
   output logic [31:0] o_f_data,
   input  logic        i_d_req,
   input  logic        i_d_write,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   input  logic [1:0]  i_d_size,
   output logic        o_d_done,
   output logic        o_d_err,
   output logic [31:0] o_d_rdata,
   output logic        o_m_req,
   output logic        o_m_write,
   output logic [31:0] o_m_addr,
   output logic [31:0] o_m_wdata,
   output logic [1:0]  o_m_size,
   input  logic        i_m_ready,
   input  logic [31:0] i_m_rdata,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        write_q;

   logic        idle;
   logic        sel_d;
   logic        sel_f;
   logic        d_none;
   logic        d_mis;
   logic        f_mis;
   logic        d_go;
   logic        f_go;
   logic [3:0]  cnt_inc;

   // Requester selection and alignment checks, only meaningful in IDLE.
   always_comb begin
      idle    = (state == IDLE);
      sel_d   = idle && i_d_req && (!i_f_req || (cnt < STARVE_LIM));
      sel_f   = idle && !sel_d && i_f_req;
      d_none  = (i_d_size == SZ_NONE);
      d_mis   = 1'b0;
      unique case (1'b1)
         (i_d_size == SZ_HALF): d_mis = i_d_addr[0];
         (i_d_size == SZ_WORD): d_mis = |i_d_addr[1:0];
         default:               d_mis = 1'b0;
      endcase
      f_mis   = |i_f_addr[1:0];
      d_go    = sel_d && !d_none && !d_mis;
      f_go    = sel_f && !f_mis;
      cnt_inc = (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
   end

   // Transaction FSM: grants in IDLE, waits for memory in FETCH/DATA.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (d_go) begin
                  addr_q  <= i_d_addr;
                  wdata_q <= i_d_wdata;
                  size_q  <= i_d_size;
                  write_q <= i_d_write;
                  cnt     <= i_f_req ? cnt_inc : 4'd0;
                  state   <= DATA;
               end else if (f_go) begin
                  addr_q  <= i_f_addr;
                  size_q  <= SZ_WORD;
                  write_q <= 1'b0;
                  cnt     <= '0;
                  state   <= FETCH;
               end
            end
            FETCH, DATA: begin
               if (i_m_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory side follows the latched transaction; request only when active.
   always_comb begin
      o_busy    = !idle;
      o_m_req   = !idle;
      o_m_write = write_q;
      o_m_addr  = addr_q;
      o_m_wdata = wdata_q;
      o_m_size  = size_q;
   end

   // Completions: immediate for rejected/empty requests, else on memory ready.
   always_comb begin
      o_f_err   = i_rst_n && sel_f && f_mis;
      o_f_valid = o_f_err ||
                  (i_rst_n && (state == FETCH) && i_m_ready);
      o_f_data  = (state == FETCH) ? i_m_rdata : '0;
      o_d_err   = i_rst_n && sel_d && !d_none && d_mis;
      o_d_done  = (i_rst_n && sel_d && (d_none || d_mis)) ||
                  (i_rst_n && (state == DATA) && i_m_ready);
      o_d_rdata = (state == DATA) ? i_m_rdata : '0;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the CPU's instruction-fetch path and its load/store path, replacing separate instruction and data buses.
- Sits between the CPU core and the memory model or BRAM wrapper.
- Sequences one transaction at a time over a req/ready handshake.
- Prioritises data accesses and includes a starvation guard so fetch always makes progress.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while fetch is pending before fetch is forced. Legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_f_req  in  1  fetch request, level, held until o_f_valid
- i_f_addr  in  32  fetch address
- o_f_valid  out  1  fetch complete this cycle
- o_f_err  out  1  fetch misaligned, qualifies o_f_valid
- o_f_data  out  32  fetched instruction
- i_d_req  in  1  data request, level, held until o_d_done
- i_d_write  in  1  1 = store, 0 = load
- i_d_addr  in  32  data address
- i_d_wdata  in  32  store data
- i_d_size  in  2  01 = byte, 10 = half, 11 = word, 00 = no access
- o_d_done  out  1  data access complete this cycle
- o_d_err  out  1  data misaligned, qualifies o_d_done
- o_d_rdata  out  32  raw load word (sign/zero extension done by the core)
- o_m_req  out  1  memory request
- o_m_write  out  1  memory write enable
- o_m_addr  out  32  memory address
- o_m_wdata  out  32  memory write data
- o_m_size  out  2  memory access size, same encoding as i_d_size
- i_m_ready  in  1  memory completes the access this cycle
- i_m_rdata  in  32  memory read data, valid when i_m_ready
- o_busy  out  1  state != IDLE

Behaviour:

States and reset:
- States: IDLE, FETCH, DATA.
- Async reset: state = IDLE, starve counter = 0, latched address/data/size/write = 0.
- While reset is asserted, all outputs are 0.
- Reset asserted mid-transaction abandons the transaction: o_m_req drops immediately and no done/valid is issued.

IDLE selection (evaluated each cycle):
- If i_d_req and (!i_f_req or cnt < STARVE_MAX): data is selected.
- Else if i_f_req: fetch is selected.
- Else remain in IDLE.

Data selected in IDLE:
- If i_d_size == 00: o_d_done = 1 combinationally this cycle, o_d_err = 0, no memory access, stay in IDLE, counter unchanged.
- If misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): o_d_done = 1 and o_d_err = 1 combinationally, no memory access, stay in IDLE.
- Otherwise, at the edge: latch addr, wdata, size and write; go to DATA.
- On that grant, cnt = min(cnt+1, STARVE_MAX) if i_f_req is high, else cnt = 0.

Fetch selected in IDLE:
- If i_f_addr[1:0] != 0: o_f_valid = 1 and o_f_err = 1 combinationally, stay in IDLE.
- Otherwise, at the edge: latch address; size = 11, write = 0; go to FETCH; cnt = 0.

FETCH/DATA states:
- o_m_req = 1 and o_m_* driven from the latched registers. Requester inputs may change without effect.
- When i_m_ready = 1: o_f_valid (FETCH) or o_d_done (DATA) = 1 combinationally that cycle.
  - o_f_data / o_d_rdata = i_m_rdata (o_d_rdata is don't-care for stores).
  - Next state is IDLE.
- Requesters drop req on the same edge as done. The mandatory IDLE cycle prevents re-granting a stale request.

Outputs outside active states:
- In IDLE: o_m_req = 0; o_m_addr, o_m_wdata, o_m_size and o_m_write hold the latched values.
- i_m_ready outside FETCH/DATA is ignored.

Timing and edge cases:
- Minimum latency from req (in IDLE) to done is 2 cycles when memory is zero-wait. Maximum throughput is one access per 2 cycles.
- A requester deasserting req mid-transaction does not abort it; done still pulses.
- No timeout; a memory that never asserts i_m_ready hangs the arbiter (the bench must check this is the only stall path).

Test Plan:
- Fetch only, addr 0x100, memory ready 1 cycle after o_m_req, rdata 0x00500093 -> o_m_req high 2 cycles, o_m_addr 0x100, size 11, o_f_valid pulse with o_f_data 0x00500093.
- Simultaneous i_f_req and i_d_req (store word 0xDEADBEEF to 0x200) -> DATA granted first with o_m_write = 1 and o_m_wdata 0xDEADBEEF; then IDLE, then FETCH.
- i_d_req held continuously with i_f_req high, STARVE_MAX = 4 -> exactly 4 data grants, then a fetch grant, counter back to 0.
- Misaligned load half at 0x201 -> o_d_done = o_d_err = 1 in the same cycle, o_m_req never asserted. Fetch at 0x102 -> o_f_err = 1.
- i_d_size 00 with i_d_req -> o_d_done in the IDLE cycle, no memory access, starve counter unchanged.
- Assert i_rst_n low while in DATA with i_m_ready low -> o_m_req and o_busy drop without a clock edge. After release, state is IDLE and the next fetch proceeds normally.
